// File: rtl/fifo_pkg.sv
// Shared sizing helpers and default parameter values for the FWFT FIFO.
package fifo_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_FIFO_DEPTH = 8;
    localparam int unsigned DEF_AEMPTY_TH  = 1;

    // Address width for a memory of 'depth' entries (at least one bit).
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width able to hold every occupancy value 0..depth.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port 1W1R memory with a registered read port; contents are not reset.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEF_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         wen,
    input  logic [ptr_width(DEPTH)-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic                         ren,
    input  logic [ptr_width(DEPTH)-1:0]  raddr,
    output logic [DATA_WIDTH-1:0]        rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Read-during-write to the same address returns the old contents.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
        if (ren) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo_fwft_prog.sv
// First-word-fall-through FIFO with programmable almost-empty/almost-full flags.
// Optional sticky overflow/underflow flags are enabled with `define FIFO_FWFT_ERR_EN.
module fifo_fwft_prog
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned AEMPTY_TH  = DEF_AEMPTY_TH,
    parameter int unsigned AFULL_TH   = FIFO_DEPTH - 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                wen_i,
    input  logic [DATA_WIDTH-1:0]               wdata_i,
    output logic                                full_o,
    output logic                                afull_o,
    input  logic                                ren_i,
    output logic [DATA_WIDTH-1:0]               rdata_o,
    output logic                                empty_o,
    output logic                                aempty_o,
    output logic [cnt_width(FIFO_DEPTH)-1:0]    count_o,
    output logic                                ovf_o,
    output logic                                udf_o,
    input  logic                                err_clr_i
);

    localparam int unsigned PW = ptr_width(FIFO_DEPTH);
    localparam int unsigned CW = cnt_width(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [PW-1:0]         rptr_nxt;
    logic [CW-1:0]         mem_cnt;
    logic [CW-1:0]         mem_cnt_nxt;
    logic [CW-1:0]         count_nxt;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  load;
    logic                  byp_sel;
    logic [DATA_WIDTH-1:0] byp_data;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [DATA_WIDTH-1:0] head_word;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // mem_cnt counts words still in memory; the output register holds the head.
    always_comb begin
        wr_acc      = wen_i && !full_o;
        rd_acc      = ren_i && !empty_o;
        load        = (empty_o || rd_acc) && (mem_cnt != '0);
        rptr_nxt    = load ? next_ptr(rptr) : rptr;
        mem_cnt_nxt = mem_cnt + CW'(wr_acc) - CW'(load);
        count_nxt   = count_o + CW'(wr_acc) - CW'(rd_acc);
        head_word   = byp_sel ? byp_data : ram_rdata;
    end

    // The memory always prefetches the next head; a word written to that
    // address on the same edge is taken from the bypass register instead.
    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_ram (
        .clk   (clk),
        .wen   (wr_acc),
        .waddr (wptr),
        .wdata (wdata_i),
        .ren   (1'b1),
        .raddr (rptr_nxt),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            mem_cnt  <= '0;
            count_o  <= '0;
            empty_o  <= 1'b1;
            aempty_o <= 1'b1;
            full_o   <= 1'b0;
            afull_o  <= 1'b0;
            rdata_o  <= '0;
            byp_sel  <= 1'b0;
            byp_data <= '0;
        end else begin
            if (wr_acc) begin
                wptr     <= next_ptr(wptr);
                byp_data <= wdata_i;
            end
            byp_sel  <= wr_acc && (wptr == rptr_nxt);
            rptr     <= rptr_nxt;
            mem_cnt  <= mem_cnt_nxt;
            count_o  <= count_nxt;
            if (load) begin
                rdata_o <= head_word;
                empty_o <= 1'b0;
            end else if (rd_acc) begin
                empty_o <= 1'b1;
            end
            full_o   <= (count_nxt == DEPTH_C);
            afull_o  <= (32'(count_nxt) >= AFULL_TH);
            aempty_o <= (32'(count_nxt) <= AEMPTY_TH);
        end
    end

`ifdef FIFO_FWFT_ERR_EN
    // Sticky error flags; a new error on the clearing cycle keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_o <= 1'b0;
            udf_o <= 1'b0;
        end else begin
            if (wen_i && full_o) begin
                ovf_o <= 1'b1;
            end else if (err_clr_i) begin
                ovf_o <= 1'b0;
            end
            if (ren_i && empty_o) begin
                udf_o <= 1'b1;
            end else if (err_clr_i) begin
                udf_o <= 1'b0;
            end
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr_i;
    assign ovf_o = 1'b0;
    assign udf_o = 1'b0;
`endif

endmodule
